// File: rtl/mehrzyklus_alu.sv
// mehrzyklus_alu: multi-cycle ALU with Start/Bereit/Fertig handshake, iterative divider and square root
module mehrzyklus_alu #(
  parameter int BREITE     = 32,
  parameter int SCHIEBBITS = 5
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [BREITE-1:0] Daten1,
  input  logic [BREITE-1:0] Daten2,
  input  logic [5:0]        FunktionsCode,
  input  logic              Start,
  output logic              Bereit,
  output logic              Fertig,
  output logic [BREITE-1:0] Ergebnis,
  output logic              DivNull
);
  localparam int CW = SCHIEBBITS + 1;
  typedef enum logic [1:0] {LEER, RECHNE_DIV, RECHNE_WURZEL, AUSGABE} zustand_t;
  zustand_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BREITE-1:0] x_q, x_d, y_q, y_d, r_q, r_d, erg_q, erg_d;
  logic mod_q, mod_d, negq_q, negq_d, negr_q, negr_d, dz_q, dz_d;
  logic [4:0] op;
  logic uns, eq, lt, sa, sb, sq_ok;
  logic [SCHIEBBITS-1:0] sh, shn;
  logic [BREITE-1:0] simple, a_mag, b_mag, sq_r, sq_t, q_fin, r_fin;
  logic [BREITE:0] dshift, ddiff;
  always_comb begin
    op = FunktionsCode[4:0];
    uns = FunktionsCode[5];
    sh = Daten2[SCHIEBBITS-1:0];
    shn = -sh;
    eq = Daten1 == Daten2;
    lt = uns ? Daten1 < Daten2 : $signed(Daten1) < $signed(Daten2);
    sa = !uns && Daten1[BREITE-1];
    sb = !uns && Daten2[BREITE-1];
    a_mag = sa ? -Daten1 : Daten1;
    b_mag = sb ? -Daten2 : Daten2;
    simple = '0;
    case (op)
      5'b00000: simple = Daten1 + Daten2;
      5'b00001: simple = Daten1 - Daten2;
      5'b00010: simple = Daten1 * Daten2;
      5'b00110: simple = Daten1 << sh;
      5'b00111: simple = Daten1 >> sh;
      5'b01000: simple = (Daten1 << sh) | (Daten1 >> shn);
      5'b01001: simple = (Daten1 >> sh) | (Daten1 << shn);
      5'b10000: simple = BREITE'(eq);
      5'b10001: simple = BREITE'(!eq);
      5'b10010: simple = BREITE'(!lt && !eq);
      5'b10011: simple = BREITE'(!lt);
      5'b10100: simple = BREITE'(lt);
      5'b10101: simple = BREITE'(lt || eq);
      5'b11000: simple = ~Daten1;
      5'b11001: simple = Daten1 & Daten2;
      5'b11010: simple = Daten1 | Daten2;
      5'b11011: simple = Daten1 ^ Daten2;
      5'b11100: simple = ~(Daten1 ^ Daten2);
      default:  simple = '0;
    endcase
  end
  always_comb begin
    dshift = {r_q, x_q[BREITE-1]};
    ddiff = dshift - {1'b0, y_q};
    sq_r = {r_q[BREITE-3:0], x_q[BREITE-1:BREITE-2]};
    sq_t = {y_q[BREITE-3:0], 2'b01};
    sq_ok = sq_r >= sq_t;
    q_fin = negq_q ? -x_q : x_q;
    r_fin = negr_q ? -r_q : r_q;
  end
  // Magnitudes are taken in the Start cycle itself, so the divider starts iterating right away
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    x_d = x_q;
    y_d = y_q;
    r_d = r_q;
    erg_d = erg_q;
    mod_d = mod_q;
    negq_d = negq_q;
    negr_d = negr_q;
    dz_d = dz_q;
    case (state_q)
      LEER: if (Start) begin
        cnt_d = '0;
        r_d = '0;
        dz_d = 1'b0;
        if (op == 5'b00011) begin
          state_d = RECHNE_WURZEL;
          x_d = Daten1;
          y_d = '0;
        end else if (op == 5'b00100 || op == 5'b00101) begin
          if (Daten2 == '0) begin
            state_d = AUSGABE;
            erg_d = op[0] ? Daten1 : '1;
            dz_d = 1'b1;
          end else begin
            state_d = RECHNE_DIV;
            x_d = a_mag;
            y_d = b_mag;
            mod_d = op[0];
            negq_d = sa ^ sb;
            negr_d = sa;
          end
        end else begin
          state_d = AUSGABE;
          erg_d = simple;
        end
      end
      RECHNE_DIV: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(BREITE)) begin
          state_d = AUSGABE;
          erg_d = mod_q ? r_fin : q_fin;
        end else begin
          r_d = ddiff[BREITE] ? dshift[BREITE-1:0] : ddiff[BREITE-1:0];
          x_d = {x_q[BREITE-2:0], !ddiff[BREITE]};
        end
      end
      RECHNE_WURZEL: begin
        cnt_d = cnt_q + 1'b1;
        x_d = x_q << 2;
        r_d = sq_ok ? sq_r - sq_t : sq_r;
        y_d = {y_q[BREITE-2:0], sq_ok};
        state_d = cnt_q == CW'(BREITE / 2 - 1) ? AUSGABE : RECHNE_WURZEL;
        erg_d = cnt_q == CW'(BREITE / 2 - 1) ? {y_q[BREITE-2:0], sq_ok} : erg_q;
      end
      default: state_d = LEER;
    endcase
  end
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q <= LEER;
      cnt_q <= '0;
      x_q <= '0;
      y_q <= '0;
      r_q <= '0;
      erg_q <= '0;
      mod_q <= 1'b0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
      dz_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      x_q <= x_d;
      y_q <= y_d;
      r_q <= r_d;
      erg_q <= erg_d;
      mod_q <= mod_d;
      negq_q <= negq_d;
      negr_q <= negr_d;
      dz_q <= dz_d;
    end
  end
  assign Bereit = state_q == LEER;
  assign Fertig = state_q == AUSGABE;
  assign Ergebnis = erg_q;
  assign DivNull = dz_q;
endmodule

// File: tb/tb_mehrzyklus_alu.sv
// tb_mehrzyklus_alu: table-driven check of results, DivNull and latency, plus handshake/reset sequences
module tb_mehrzyklus_alu;
  logic Clock = 1'b0, Reset = 1'b0, Start = 1'b0;
  logic [31:0] Daten1 = '0, Daten2 = '0;
  logic [5:0] FunktionsCode = '0;
  logic Bereit, Fertig, DivNull;
  logic [31:0] Ergebnis;
  int checks = 0, failures = 0;

  typedef struct {
    string nm;
    logic [5:0] fc;
    logic [31:0] a, b, exp;
    logic dz;
    int lat;
  } vec_t;
  vec_t v[$];

  mehrzyklus_alu #(.BREITE(32), .SCHIEBBITS(5)) dut (
    .Clock(Clock), .Reset(Reset), .Daten1(Daten1), .Daten2(Daten2),
    .FunktionsCode(FunktionsCode), .Start(Start), .Bereit(Bereit),
    .Fertig(Fertig), .Ergebnis(Ergebnis), .DivNull(DivNull)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic add(input string nm, input logic [5:0] fc, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input logic dz, input int lat);
    vec_t e;
    e.nm = nm; e.fc = fc; e.a = a; e.b = b; e.exp = exp; e.dz = dz; e.lat = lat;
    v.push_back(e);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!Bereit && n < 200) begin
      @(negedge Clock);
      n++;
    end
  endtask

  task automatic run(input logic [5:0] fc, input logic [31:0] a, input logic [31:0] b, output int lat);
    wait_ready();
    FunktionsCode = fc; Daten1 = a; Daten2 = b; Start = 1'b1;
    lat = 1;
    @(negedge Clock);
    Start = 1'b0; Daten1 = $urandom(); Daten2 = $urandom(); FunktionsCode = 6'($urandom());
    lat = 2;
    while (!Fertig && lat < 200) begin
      @(negedge Clock);
      lat++;
    end
  endtask

  initial begin
    int lat, pulses;
    logic [31:0] r;
    add("add_ovf",  6'b000000, 32'h7FFFFFFF, 32'h1,        32'h80000000, 0, 2);
    add("sub",      6'b000001, 32'h0,        32'h1,        32'hFFFFFFFF, 0, 2);
    add("mul",      6'b000010, 32'h00010000, 32'h00010001, 32'h00010000, 0, 2);
    add("shl31",    6'b000110, 32'h1,        32'd31,       32'h80000000, 0, 2);
    add("shr31",    6'b000111, 32'h80000000, 32'd31,       32'h1,        0, 2);
    add("rotl4",    6'b001000, 32'h80000001, 32'd4,        32'h00000018, 0, 2);
    add("rotr1",    6'b001001, 32'h1,        32'd1,        32'h80000000, 0, 2);
    add("div_s",    6'b000100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 0, 35);
    add("mod_s",    6'b000101, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 0, 35);
    add("div_sb",   6'b000100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 0, 35);
    add("mod_sb",   6'b000101, 32'd7,        32'hFFFFFFFE, 32'h1,        0, 35);
    add("div_u",    6'b100100, 32'hFFFFFFFF, 32'h10,       32'h0FFFFFFF, 0, 35);
    add("div_umin", 6'b100100, 32'h80000000, 32'hFFFFFFFF, 32'h0,        0, 35);
    add("div_min",  6'b000100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 35);
    add("mod_min",  6'b000101, 32'h80000000, 32'hFFFFFFFF, 32'h0,        0, 35);
    add("div0",     6'b000100, 32'd5,        32'h0,        32'hFFFFFFFF, 1, 2);
    add("mod0",     6'b000101, 32'd5,        32'h0,        32'h5,        1, 2);
    add("sqrt_max", 6'b000011, 32'hFFFFFFFF, 32'h0,        32'h0000FFFF, 0, 18);
    add("sqrt0",    6'b000011, 32'h0,        32'h0,        32'h0,        0, 18);
    add("sqrt99",   6'b100011, 32'd99,       32'h0,        32'd9,        0, 18);
    add("gt_s",     6'b010010, 32'hFFFFFFFF, 32'h1,        32'h0,        0, 2);
    add("gt_u",     6'b110010, 32'hFFFFFFFF, 32'h1,        32'h1,        0, 2);
    add("eq",       6'b010000, 32'd5,        32'd5,        32'h1,        0, 2);
    add("ne",       6'b010001, 32'd5,        32'd5,        32'h0,        0, 2);
    add("ge_s",     6'b010011, 32'h80000000, 32'h0,        32'h0,        0, 2);
    add("lt_s",     6'b010100, 32'hFFFFFFFF, 32'h1,        32'h1,        0, 2);
    add("le_u",     6'b110101, 32'h1,        32'h1,        32'h1,        0, 2);
    add("not",      6'b011000, 32'h0F0F0000, 32'h0,        32'hF0F0FFFF, 0, 2);
    add("and",      6'b011001, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0, 2);
    add("or",       6'b011010, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 0, 2);
    add("xor",      6'b011011, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 0, 2);
    add("xnor",     6'b011100, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF00FF00F, 0, 2);
    add("invalid",  6'b001010, 32'h12345678, 32'h9,        32'h0,        0, 2);

    repeat (3) @(negedge Clock);
    chk("reset_bereit", 32'(Bereit), 32'h1);
    chk("reset_fertig", 32'(Fertig), 32'h0);
    chk("reset_erg", Ergebnis, 32'h0);
    chk("reset_dz", 32'(DivNull), 32'h0);
    Reset = 1'b1;
    @(negedge Clock);

    foreach (v[i]) begin
      run(v[i].fc, v[i].a, v[i].b, lat);
      chk({v[i].nm, "_erg"}, Ergebnis, v[i].exp);
      chk({v[i].nm, "_dz"}, 32'(DivNull), 32'(v[i].dz));
      chk({v[i].nm, "_lat"}, 32'(lat), 32'(v[i].lat));
      @(negedge Clock);
      chk({v[i].nm, "_pulse"}, {30'h0, Fertig, Bereit}, 32'h1);
    end

    // Start while busy must be ignored
    wait_ready();
    FunktionsCode = 6'b000100; Daten1 = 32'd100; Daten2 = 32'd7; Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    repeat (3) @(negedge Clock);
    FunktionsCode = 6'b000000; Daten1 = 32'd1; Daten2 = 32'd1; Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    pulses = 0; r = '0;
    for (int n = 0; n < 60; n++) begin
      if (Fertig) begin
        pulses++;
        r = Ergebnis;
      end
      @(negedge Clock);
    end
    chk("busy_pulses", 32'(pulses), 32'h1);
    chk("busy_erg", r, 32'd14);

    // back-to-back add then xor, Start held high
    wait_ready();
    FunktionsCode = 6'b000000; Daten1 = 32'd3; Daten2 = 32'd4; Start = 1'b1;
    @(negedge Clock);
    chk("b2b_f1", 32'(Fertig), 32'h1);
    chk("b2b_add", Ergebnis, 32'd7);
    FunktionsCode = 6'b011011; Daten1 = 32'hAAAA0000; Daten2 = 32'h0000AAAA;
    @(negedge Clock);
    chk("b2b_bereit", 32'(Bereit), 32'h1);
    @(negedge Clock);
    Start = 1'b0;
    chk("b2b_f2", 32'(Fertig), 32'h1);
    chk("b2b_xor", Ergebnis, 32'hAAAAAAAA);

    // reset during a running division
    @(negedge Clock);
    FunktionsCode = 6'b000100; Daten1 = 32'd1000; Daten2 = 32'd3; Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    repeat (4) @(negedge Clock);
    Reset = 1'b0;
    repeat (3) @(negedge Clock);
    Reset = 1'b1;
    chk("rst_bereit", 32'(Bereit), 32'h1);
    chk("rst_erg", Ergebnis, 32'h0);
    pulses = 0;
    for (int n = 0; n < 40; n++) begin
      if (Fertig) pulses++;
      @(negedge Clock);
    end
    chk("rst_nofertig", 32'(pulses), 32'h0);
    chk("rst_erg_hold", Ergebnis, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mehrzyklus_alu.md
Name: mehrzyklus_alu

Overview:
- Parametrised, fully synchronous successor to the processor ALU.
- Replaces the edge-triggered StartSignal/Schreibsignal scheme with a single-clock Start/Bereit/Fertig handshake.
- Integrates an iterative restoring divider (signed/unsigned quotient and remainder) and an iterative integer square root.
- Sits between register-file read and write-back in the Prozessor. The control unit stalls while Bereit is low.

Parameters:
- BREITE, 32: operand/result width in bits; even, >= 8.
- SCHIEBBITS, 5: shift-amount bits taken from Daten2; must equal clog2(BREITE).

Ports:
- Clock  in  1  system clock, all state on rising edge
- Reset  in  1  synchronous, active-low reset
- Daten1  in  BREITE  operand A
- Daten2  in  BREITE  operand B
- FunktionsCode  in  6  [4:0] operation, [5] 1 = unsigned mode
- Start  in  1  request; sampled only when Bereit=1
- Bereit  out  1  ready to accept Start
- Fertig  out  1  one-cycle pulse, Ergebnis valid
- Ergebnis  out  BREITE  result, held until the next Fertig
- DivNull  out  1  valid with Fertig: division/modulo by zero

Behaviour:
- Reset (Reset=0 at a rising edge): state LEER, Bereit=1, Fertig=0, Ergebnis=0, DivNull=0. Reset aborts any operation in progress; no Fertig is issued for it.
- Operand capture: on Start=1 with Bereit=1, Daten1, Daten2 and FunktionsCode are registered. Inputs may change afterwards. Start while Bereit=0 is ignored.
- States:
  - LEER: Bereit=1.
  - RECHNE_DIV, RECHNE_WURZEL: Bereit=0.
  - AUSGABE: Bereit=0, Fertig=1 for exactly one cycle, then return to LEER.
- Codes [4:0]:
  - 00000 add, 00001 sub, 00010 mul (low BREITE bits). Modulo 2^BREITE, no flags.
  - 00011 sqrt: floor(sqrt(Daten1)), always unsigned.
  - 00100 div, 00101 mod.
  - 00110 shl, 00111 shr (logical). Shift amount is Daten2[SCHIEBBITS-1:0].
  - 01000 rotl, 01001 rotr.
  - 10000 ==, 10001 !=, 10010 >, 10011 >=, 10100 <, 10101 <=. Result is 0 or 1, zero-extended. Signed compare unless [5]=1.
  - 11000 not A, 11001 and, 11010 or, 11011 xor, 11100 xnor.
  - Any other code: Ergebnis=0, normal Fertig.
- Latency, counted from the Start edge to the Fertig cycle:
  - Simple ops: 2 cycles (LEER -> AUSGABE).
  - Div/mod: BREITE+3 cycles. One cycle takes magnitudes (signed mode), BREITE restoring iterations, one cycle applies sign correction, then AUSGABE.
  - Sqrt: BREITE/2+2 cycles, digit-by-digit method, two radicand bits per iteration.
- Bereit returns to 1 in the cycle after Fertig. Back-to-back Start is allowed whenever Bereit=1.
- Division semantics:
  - Signed mode truncates toward zero; the remainder takes the sign of the dividend.
  - Divisor 0: quotient all-ones, remainder = Daten1, DivNull=1, latency 2 (no iteration).
  - Signed MIN / -1: quotient = MIN, remainder 0, DivNull=0.
- DivNull equals 0 for every non-div/mod operation.
- Ergebnis and DivNull change only in the AUSGABE cycle.

Test Plan:
- Reset held low 3 cycles during a running division, then released -> Bereit=1, Fertig never pulses, Ergebnis=0.
- add 0x7FFFFFFF + 1 -> Ergebnis=0x80000000, Fertig exactly 2 cycles after Start. shl 0x1 by 31 -> 0x80000000. rotr 0x00000001 by 1 -> 0x80000000.
- signed div -7 / 2 -> Fertig after 35 cycles, Ergebnis=0xFFFFFFFD (-3). mod -7 % 2 -> 0xFFFFFFFF (-1). Unsigned div 0xFFFFFFFF / 0x10 -> 0x0FFFFFFF.
- div 5 / 0 -> Ergebnis=0xFFFFFFFF, DivNull=1, latency 2. mod 5 % 0 -> Ergebnis=5, DivNull=1. Signed 0x80000000 / 0xFFFFFFFF -> 0x80000000, DivNull=0.
- sqrt 0xFFFFFFFF -> 0x0000FFFF after 18 cycles. sqrt 0 -> 0. sqrt 99 -> 9.
- Compare 0xFFFFFFFF > 1: signed -> 0, unsigned ([5]=1) -> 1. Start pulsed while Bereit=0 -> ignored, only one Fertig. Back-to-back add then xor -> two Fertig pulses with correct results.
